ens0_layer1_out_skid: RTL

Registered valid/ready boundary stage placed directly downstream of the ens0 layer-1 neuron LUTs (one 1-bit output per neuron). It captures the concatenated layer-1 output vector and hands it to the layer-2 fan-in wiring. The two-entry skid buffer lets layer 2 apply backpressure without a combinational ready path back into layer 1. It also keeps a wrap-around count of vectors delivered, for bench and debug correlation.

---
 rtl/ens0_layer1_out_skid_if.sv | 50 +++++
 rtl/ens0_layer1_out_skid.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ens0_layer1_out_skid_if.sv
// ----------------------------------------------------------------------------
// ens0_layer1_out_skid_if
//   Handshake bundle between the ens0 layer-1 LUT outputs, the boundary skid
//   stage and the layer-2 fan-in wiring.
//
//   Signals
//     in_data      [WIDTH]  layer-1 LUT outputs, bit i = neuron N<i>
//     in_valid              in_data holds a complete vector
//     in_ready              stage can accept a vector
//     out_data     [WIDTH]  vector presented to layer 2
//     out_valid             out_data valid
//     out_ready             layer 2 accepts out_data
//     sample_count [CNT_W]  completed output transfers, wrapping
//
//   Modports
//     master : the environment (drives producer side and consumer ready)
//     slave  : the skid stage itself
// ----------------------------------------------------------------------------
interface ens0_layer1_out_skid_if #(
   parameter int WIDTH = 1024,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] sample_count;

   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_data,
      input  out_valid,
      input  sample_count
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_data,
      output out_valid,
      output sample_count
   );
endinterface

// File: rtl/ens0_layer1_out_skid.sv
// ----------------------------------------------------------------------------
// ens0_layer1_out_skid
//   Registered valid/ready boundary between the ens0 layer-1 neuron LUTs and
//   the layer-2 fan-in. A main register drives the outputs and a skid
//   register absorbs the one vector that can arrive in the cycle layer 2
//   first applies backpressure, so in_ready never depends combinationally
//   on out_ready. Also counts delivered vectors (wrapping) for debug.
//
//   Ports
//     clk   : single clock, rising edge
//     rst   : synchronous, active-high reset; wins over any transfer
//     bus   : ens0_layer1_out_skid_if.slave handshake bundle
//
//   Occupancy states (main_valid, skid_valid)
//     ST_EMPTY (0,0), ST_ONE (1,0), ST_FULL (1,1)
// ----------------------------------------------------------------------------
module ens0_layer1_out_skid #(
   parameter int WIDTH = 1024,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   ens0_layer1_out_skid_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q,  in_ready_d;
   logic [CNT_W-1:0] count_q,     count_d;

   logic             accept_s;
   logic             deliver_s;

   // Next-state, data steering and counter update.
   always_comb begin
      accept_s    = bus.in_valid & in_ready_q;
      deliver_s   = out_valid_q & bus.out_ready;
      state_d     = state_q;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;

      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               main_data_d = bus.in_data;
               state_d     = ST_ONE;
            end else begin
               state_d     = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && deliver_s) begin
               // Pass-through: head leaves, new vector takes its place.
               main_data_d = bus.in_data;
               state_d     = ST_ONE;
            end else if (accept_s) begin
               // Consumer stalled: park the new vector behind the head.
               skid_data_d = bus.in_data;
               state_d     = ST_FULL;
            end else if (deliver_s) begin
               state_d     = ST_EMPTY;
            end else begin
               state_d     = ST_ONE;
            end
         end
         ST_FULL: begin
            // in_ready_q is low here, so accept_s cannot be set.
            if (deliver_s) begin
               main_data_d = skid_data_q;
               state_d     = ST_ONE;
            end else begin
               state_d     = ST_FULL;
            end
         end
         default: begin
            // Unreachable encoding (main empty, skid full): recover to empty.
            state_d     = ST_EMPTY;
         end
      endcase

      if (deliver_s) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end

      // Handshake outputs are registered copies of the next occupancy.
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_FULL);
   end

   // State, data and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_data_q <= {WIDTH{1'b0}};
         skid_data_q <= {WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         count_q     <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         skid_data_q <= skid_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         count_q     <= count_d;
      end
   end

   assign bus.out_data     = main_data_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.in_ready     = in_ready_q;
   assign bus.sample_count = count_q;

endmodule
